// File: rtl/instr_pkg.sv
// Shared definitions for the instruction issuer: the ALU opcode encoding,
// the 16-bit instruction field layout, the bubble word and the issue FSM states.
package instr_pkg;

   // ALU opcode encoding
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLL  = 3'b101;
   localparam logic [2:0] OP_SRL  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   // Instruction word layout: {opcode, src_a, src_b, dest, 4'b0000}
   localparam int INSTR_W  = 16;
   localparam int OPC_W    = 3;
   localparam int REG_W    = 3;
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 13;
   localparam int SRCA_MSB = 12;
   localparam int SRCA_LSB = 10;
   localparam int SRCB_MSB = 9;
   localparam int SRCB_LSB = 7;
   localparam int DEST_MSB = 6;
   localparam int DEST_LSB = 4;
   localparam int PAD_MSB  = 3;

   // Word driven into the processor during bubble slots
   localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } issue_state_e;

   function automatic logic [INSTR_W-1:0] pack_instr(
      input logic [OPC_W-1:0] opc,
      input logic [REG_W-1:0] src_a,
      input logic [REG_W-1:0] src_b,
      input logic [REG_W-1:0] dest
   );
      return {opc, src_a, src_b, dest, {(PAD_MSB + 1){1'b0}}};
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO. Refuses pushes when full and pops when empty;
// head_o shows the oldest entry whenever empty_o is low. DEPTH must be a
// power of two so the pointers wrap naturally.
module instr_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   // Control state; reset empties the FIFO without touching storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: packs host-supplied fields into 16-bit instruction
// words, buffers them in instr_fifo and drives one registered word per clock
// into the processor, inserting NOP bubbles when empty, paused or stalled.
// Build option: define HAZARD_INTERLOCK_EN to stall a head instruction that
// reads a register written within the last HAZARD_GAP issue slots. Without
// it the history is still maintained but never stalls issue.
module instr_issuer
   import instr_pkg::*;
#(
   parameter int          DEPTH      = 8,
   parameter int          HAZARD_GAP = 2,
   parameter logic [15:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             in_opcode,
   input  logic [2:0]             in_src_a,
   input  logic [2:0]             in_src_b,
   input  logic [2:0]             in_dest,
   input  logic                   issue_en,
   output logic [15:0]            instruction,
   output logic                   issue_valid,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [15:0]            issued_count
);

`ifdef HAZARD_INTERLOCK_EN
   localparam bit HAZ_EN = 1'b1;
`else
   localparam bit HAZ_EN = 1'b0;
`endif

   issue_state_e state_q, state_d;

   logic [INSTR_W-1:0] in_word;
   logic [INSTR_W-1:0] head_word;
   logic               fifo_full, fifo_empty;
   logic               push, pop;
   logic [REG_W-1:0]   head_src_a, head_src_b, head_dest;
   logic               raw_hit, hazard;

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [15:0]        issued_q, issued_d;

   logic [HAZARD_GAP-1:0]            hist_vld_q, hist_vld_d;
   logic [HAZARD_GAP-1:0][REG_W-1:0] hist_dst_q, hist_dst_d;

   // in_ready depends only on registered FIFO occupancy
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign in_word  = pack_instr(in_opcode, in_src_a, in_src_b, in_dest);

   instr_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (in_word),
      .pop_i   (pop),
      .head_o  (head_word),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head_src_a = head_word[SRCA_MSB:SRCA_LSB];
   assign head_src_b = head_word[SRCB_MSB:SRCB_LSB];
   assign head_dest  = head_word[DEST_MSB:DEST_LSB];

   // RAW check of the head's sources against recently issued destinations
   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i < HAZARD_GAP; i++) begin
         if (hist_vld_q[i] &&
             ((hist_dst_q[i] == head_src_a) || (hist_dst_q[i] == head_src_b)))
            raw_hit = 1'b1;
      end
   end

   assign hazard = raw_hit && HAZ_EN;

   // Next-state: pause wins, then empty, then hazard, else issue the head
   always_comb begin
      state_d = IDLE;
      if (!issue_en)       state_d = IDLE;
      else if (fifo_empty) state_d = IDLE;
      else if (hazard)     state_d = STALL;
      else                 state_d = ISSUE;
   end

   // Slot outputs: pop and drive the head on ISSUE, otherwise a bubble
   always_comb begin
      pop      = (state_d == ISSUE);
      instr_d  = pop ? head_word : NOP_WORD;
      issued_d = pop ? issued_q + 16'd1 : issued_q;
      hist_vld_d[0] = pop;
      hist_dst_d[0] = head_dest;
      for (int i = 1; i < HAZARD_GAP; i++) begin
         hist_vld_d[i] = hist_vld_q[i-1];
         hist_dst_d[i] = hist_dst_q[i-1];
      end
   end

   // State, output word, issue counter and hazard history registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         instr_q    <= NOP_WORD;
         issued_q   <= '0;
         hist_vld_q <= '0;
         hist_dst_q <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         issued_q   <= issued_d;
         hist_vld_q <= hist_vld_d;
         hist_dst_q <= hist_dst_d;
      end
   end

   assign instruction  = instr_q;
   assign issue_valid  = (state_q == ISSUE);
   assign issued_count = issued_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed testbench for instr_issuer with a scoreboard of packed words.
module tb_instr_issuer;

   localparam int          DEPTH = 8;
   localparam logic [15:0] NOP   = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opcode, in_src_a, in_src_b, in_dest;
   logic        issue_en;
   logic [15:0] instruction;
   logic        issue_valid;
   logic [3:0]  fifo_count;
   logic [15:0] issued_count;

   int n_pass  = 0;
   int n_total = 0;
   int n_obs   = 0;
   logic [15:0] sb_q [$];

   instr_issuer #(
      .DEPTH      (DEPTH),
      .HAZARD_GAP (2),
      .NOP_WORD   (NOP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_src_a     (in_src_a),
      .in_src_b     (in_src_b),
      .in_dest      (in_dest),
      .issue_en     (issue_en),
      .instruction  (instruction),
      .issue_valid  (issue_valid),
      .fifo_count   (fifo_count),
      .issued_count (issued_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] pk(input logic [2:0] o, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] d);
      return {o, a, b, d, 4'b0000};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] o, input logic [2:0] a,
                      input logic [2:0] b, input logic [2:0] d);
      in_valid  = v;
      in_opcode = o;
      in_src_a  = a;
      in_src_b  = b;
      in_dest   = d;
   endtask

   // One clock: scoreboard the produced slot, then record any accepted push
   task automatic tick(input string tag);
      logic        pushed;
      logic [15:0] pw;
      pushed = in_valid && in_ready;
      pw     = pk(in_opcode, in_src_a, in_src_b, in_dest);
      @(posedge clk);
      #1;
      if (issue_valid) begin
         n_obs++;
         if (sb_q.size() == 0)
            chk({tag, "_spurious"}, 32'(issue_valid), 32'd0);
         else
            chk({tag, "_word"}, 32'(instruction), 32'(sb_q.pop_front()));
         chk({tag, "_issued"}, 32'(issued_count), 32'(n_obs));
      end else begin
         chk({tag, "_nop"}, 32'(instruction), 32'(NOP));
      end
      if (pushed) sb_q.push_back(pw);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_instr"},  32'(instruction),  32'(NOP));
      chk({tag, "_valid"},  32'(issue_valid),  32'd0);
      chk({tag, "_count"},  32'(fifo_count),   32'd0);
      chk({tag, "_issued"}, 32'(issued_count), 32'd0);
      chk({tag, "_ready"},  32'(in_ready),     32'd1);
   endtask

   logic [15:0] w_word, r_word, u_word;
   logic [15:0] exp_slot [5];

   initial begin
      reset    = 1'b1;
      issue_en = 1'b1;
      drv(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b0;

      // Single instruction: packed word two edges after the push
      drv(1'b1, 3'b010, 3'd1, 3'd2, 3'd3);
      tick("t1_push");
      drv(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      chk("t1_count", 32'(fifo_count), 32'd1);
      chk("t1_early", 32'(issue_valid), 32'd0);
      tick("t1_issue");
      chk("t1_word",   32'(instruction),  32'h4530);
      chk("t1_valid",  32'(issue_valid),  32'd1);
      chk("t1_issued", 32'(issued_count), 32'd1);
      tick("t1_after");
      chk("t1_bubble", 32'(issue_valid), 32'd0);
      chk("t1_empty",  32'(fifo_count),  32'd0);

      // Paused fill to full, refused ninth push, then burst drain
      issue_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk("t2_ready", 32'(in_ready), 32'd1);
         drv(1'b1, 3'(i), 3'(i % 7), 3'((i + 1) % 7), 3'd7);
         tick("t2_fill");
      end
      chk("t2_full_ready", 32'(in_ready),   32'd0);
      chk("t2_full_count", 32'(fifo_count), 32'd8);
      drv(1'b1, 3'd7, 3'd6, 3'd6, 3'd7);
      tick("t2_ninth");
      drv(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      chk("t2_ninth_count", 32'(fifo_count), 32'd8);
      issue_en = 1'b1;
      tick("t2_pop0");
      chk("t2_pop0_valid", 32'(issue_valid), 32'd1);
      chk("t2_pop0_ready", 32'(in_ready),    32'd1);
      chk("t2_pop0_count", 32'(fifo_count),  32'd7);
      for (int i = 1; i < DEPTH; i++) begin
         tick("t2_drain");
         chk("t2_b2b", 32'(issue_valid), 32'd1);
      end
      tick("t2_end");
      chk("t2_end_valid", 32'(issue_valid), 32'd0);
      chk("t2_end_left",  32'(sb_q.size()), 32'd0);

      // Full FIFO with in_valid held while issue resumes
      issue_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drv(1'b1, 3'(7 - i), 3'(i % 7), 3'((i + 3) % 7), 3'd7);
         tick("t3_fill");
      end
      drv(1'b1, 3'b110, 3'd5, 3'd6, 3'd7);
      issue_en = 1'b1;
      tick("t3_full");
      chk("t3_full_ready", 32'(in_ready),   32'd1);
      chk("t3_full_count", 32'(fifo_count), 32'd7);
      tick("t3_accept");
      drv(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      chk("t3_accept_count", 32'(fifo_count), 32'd7);
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick("t3_drain");
      chk("t3_leftover", 32'(sb_q.size()), 32'd0);
      chk("t3_empty",    32'(fifo_count),  32'd0);
      tick("t3_idle");

      // Write of r3 followed by a read of r3, then an unrelated instruction
      w_word = pk(3'b001, 3'd1, 3'd2, 3'd3);
      r_word = pk(3'b011, 3'd3, 3'd4, 3'd5);
      u_word = pk(3'b100, 3'd6, 3'd0, 3'd1);
`ifdef HAZARD_INTERLOCK_EN
      exp_slot[0] = w_word; exp_slot[1] = NOP;    exp_slot[2] = NOP;
      exp_slot[3] = r_word; exp_slot[4] = u_word;
`else
      exp_slot[0] = w_word; exp_slot[1] = r_word; exp_slot[2] = u_word;
      exp_slot[3] = NOP;    exp_slot[4] = NOP;
`endif
      drv(1'b1, 3'b001, 3'd1, 3'd2, 3'd3);
      tick("t4_pw");
      drv(1'b1, 3'b011, 3'd3, 3'd4, 3'd5);
      tick("t4_s0");
      chk("t4_slot0", 32'(instruction), 32'(exp_slot[0]));
      drv(1'b1, 3'b100, 3'd6, 3'd0, 3'd1);
      tick("t4_s1");
      chk("t4_slot1", 32'(instruction), 32'(exp_slot[1]));
      drv(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      tick("t4_s2");
      chk("t4_slot2", 32'(instruction), 32'(exp_slot[2]));
      tick("t4_s3");
      chk("t4_slot3", 32'(instruction), 32'(exp_slot[3]));
      tick("t4_s4");
      chk("t4_slot4", 32'(instruction), 32'(exp_slot[4]));
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) tick("t4_drain");
      chk("t4_leftover", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset while entries are buffered and issuing
      issue_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 3'(i), 3'(i % 7), 3'((i + 2) % 7), 3'd7);
         tick("t5_fill");
      end
      drv(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      issue_en = 1'b1;
      tick("t5_run");
      tick("t5_run");
      chk("t5_pre_valid", 32'(issue_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("t5_async");
      sb_q.delete();
      n_obs = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick("t5_post");
         chk("t5_post_valid", 32'(issue_valid), 32'd0);
      end
      chk("t5_post_count",  32'(fifo_count),   32'd0);
      chk("t5_post_issued", 32'(issued_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
